// File: rtl/ula_seq_16bits_if.sv
// Bus bundle for the 16-bit sequencer: request, response and 8-bit ALU legs.
// Carries req_short only when ULA_SEQ_SHORT_EN is defined.
interface ula_seq_16bits_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_s;
  logic        req_m;
  logic        req_c_in;
`ifdef ULA_SEQ_SHORT_EN
  logic        req_short;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_f;
  logic        resp_c_out;
  logic        resp_a_eq_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_c_in;
  logic [7:0]  alu_f;
  logic        alu_c_out;
  logic        alu_a_eq_b;

  modport slave (
`ifdef ULA_SEQ_SHORT_EN
    input  req_short,
`endif
    input  req_valid, req_a, req_b, req_s,
    input  req_m, req_c_in, resp_ready,
    input  alu_f, alu_c_out, alu_a_eq_b,
    output req_ready, resp_valid, resp_f,
    output resp_c_out, resp_a_eq_b,
    output alu_a, alu_b, alu_s, alu_m, alu_c_in
  );

  modport master (
`ifdef ULA_SEQ_SHORT_EN
    output req_short,
`endif
    output req_valid, req_a, req_b, req_s,
    output req_m, req_c_in, resp_ready,
    output alu_f, alu_c_out, alu_a_eq_b,
    input  req_ready, resp_valid, resp_f,
    input  resp_c_out, resp_a_eq_b,
    input  alu_a, alu_b, alu_s, alu_m, alu_c_in
  );
endinterface

// File: rtl/ula_seq_16bits.sv
// 16-bit ALU op done as two passes through an external 8-bit ula_8bits.
// ULA_SEQ_SHORT_EN adds a low-byte-only request (req_short).
module ula_seq_16bits (
  input logic             clk,
  input logic             rst_n,
  ula_seq_16bits_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_s;
  logic        r_m;
  logic        r_c_in;
`ifdef ULA_SEQ_SHORT_EN
  logic        r_short;
`endif
  logic        r_carry_lo;
  logic        r_eq_lo;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [15:0] r_f;
  logic        r_c_out;
  logic        r_eq;

  logic        w_lo;
  logic        w_hi;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic [3:0]  w_alu_s;
  logic        w_alu_m;
  logic        w_alu_c_in;

  assign w_lo = (r_state == LO);
  assign w_hi = (r_state == HI);

  // ALU legs are idle-zero outside the two compute passes
  always_comb begin
    w_alu_a    = 8'h00;
    w_alu_b    = 8'h00;
    w_alu_s    = 4'h0;
    w_alu_m    = 1'b0;
    w_alu_c_in = 1'b0;
    unique case (1'b1)
      w_lo: begin
        w_alu_a    = r_a[7:0];
        w_alu_b    = r_b[7:0];
        w_alu_s    = r_s;
        w_alu_m    = r_m;
        w_alu_c_in = r_c_in;
      end
      w_hi: begin
        w_alu_a    = r_a[15:8];
        w_alu_b    = r_b[15:8];
        w_alu_s    = r_s;
        w_alu_m    = r_m;
        w_alu_c_in = r_carry_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_s          <= 4'h0;
      r_m          <= 1'b0;
      r_c_in       <= 1'b0;
`ifdef ULA_SEQ_SHORT_EN
      r_short      <= 1'b0;
`endif
      r_carry_lo   <= 1'b0;
      r_eq_lo      <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_f          <= 16'h0000;
      r_c_out      <= 1'b0;
      r_eq         <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_s         <= bus.req_s;
            r_m         <= bus.req_m;
            r_c_in      <= bus.req_c_in;
`ifdef ULA_SEQ_SHORT_EN
            r_short     <= bus.req_short;
`endif
            r_req_ready <= 1'b0;
            r_state     <= LO;
          end
        end
        LO: begin
          r_f[7:0]   <= bus.alu_f;
          r_carry_lo <= bus.alu_c_out;
          r_eq_lo    <= bus.alu_a_eq_b;
`ifdef ULA_SEQ_SHORT_EN
          if (r_short) begin
            r_f[15:8]    <= 8'h00;
            r_c_out      <= bus.alu_c_out;
            r_eq         <= bus.alu_a_eq_b;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_state <= HI;
          end
`else
          r_state <= HI;
`endif
        end
        HI: begin
          r_f[15:8]    <= bus.alu_f;
          r_c_out      <= bus.alu_c_out;
          r_eq         <= r_eq_lo & bus.alu_a_eq_b;
          r_resp_valid <= 1'b1;
          r_state      <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_f      = r_f;
  assign bus.resp_c_out  = r_c_out;
  assign bus.resp_a_eq_b = r_eq;
  assign bus.alu_a       = w_alu_a;
  assign bus.alu_b       = w_alu_b;
  assign bus.alu_s       = w_alu_s;
  assign bus.alu_m       = w_alu_m;
  assign bus.alu_c_in    = w_alu_c_in;

endmodule

// File: tb/tb_ula_seq_16bits.sv
// Bench for ula_seq_16bits with a behavioural 8-bit ALU stub.
// Exercises req_short when ULA_SEQ_SHORT_EN is defined.
module tb_ula_seq_16bits;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ula_seq_16bits_if bus ();

  ula_seq_16bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: returns {eq, c_out, f}
  function automatic logic [9:0] alu8(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] s,
    input logic       m,
    input logic       cin
  );
    logic [8:0] sum;
    logic [7:0] f;
    logic       c;
    if (m) begin
      f = (s == 4'b0110) ? (a ^ b) : ((a & b) ^ {s, s});
      c = cin ^ a[0];
    end else begin
      sum = {1'b0, a} + {1'b0, (s[0] ? ~b : b)} + {8'h00, cin};
      f   = sum[7:0];
      c   = sum[8];
    end
    return {(a == b), c, f};
  endfunction

  assign {bus.alu_a_eq_b, bus.alu_c_out, bus.alu_f} =
    alu8(bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_c_in);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0]  s,
                       input logic        m,
                       input logic        cin,
                       input bit          shortop,
                       input bit          press);
    logic [9:0]  lo;
    logic [9:0]  hi;
    logic [15:0] ef;
    logic        ec;
    logic        eq;
    lo = alu8(a[7:0], b[7:0], s, m, cin);
    hi = alu8(a[15:8], b[15:8], s, m, lo[8]);
    if (shortop) begin
      ef = {8'h00, lo[7:0]};
      ec = lo[8];
      eq = lo[9];
    end else begin
      ef = {hi[7:0], lo[7:0]};
      ec = hi[8];
      eq = lo[9] & hi[9];
    end
    chk("idle_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_s     = s;
    bus.req_m     = m;
    bus.req_c_in  = cin;
`ifdef ULA_SEQ_SHORT_EN
    bus.req_short = shortop;
`endif
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lo_alu_a", bus.alu_a, a[7:0]);
    chk("lo_alu_b", bus.alu_b, b[7:0]);
    chk("lo_alu_s", bus.alu_s, s);
    chk("lo_alu_m", bus.alu_m, m);
    chk("lo_alu_cin", bus.alu_c_in, cin);
    chk("lo_ready", bus.req_ready, 0);
    if (!shortop) begin
      @(negedge clk);
      chk("hi_alu_a", bus.alu_a, a[15:8]);
      chk("hi_alu_b", bus.alu_b, b[15:8]);
      chk("hi_alu_cin", bus.alu_c_in, lo[8]);
      chk("hi_valid", bus.resp_valid, 0);
    end
    @(negedge clk);
    chk("done_valid", bus.resp_valid, 1);
    chk("done_f", bus.resp_f, ef);
    chk("done_c", bus.resp_c_out, ec);
    chk("done_eq", bus.resp_a_eq_b, eq);
    chk("done_alu_a", bus.alu_a, 0);
    chk("done_ready", bus.req_ready, 0);
    if (press) begin
      repeat (5) begin
        bus.req_valid = 1'b1;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        @(negedge clk);
        chk("bp_valid", bus.resp_valid, 1);
        chk("bp_f", bus.resp_f, ef);
        chk("bp_c", bus.resp_c_out, ec);
        chk("bp_eq", bus.resp_a_eq_b, eq);
        chk("bp_ready", bus.req_ready, 0);
      end
      bus.req_valid = 1'b0;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("post_valid", bus.resp_valid, 0);
    chk("post_ready", bus.req_ready, 1);
    chk("post_f_hold", bus.resp_f, ef);
    chk("post_c_hold", bus.resp_c_out, ec);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = 16'h0000;
    bus.req_b      = 16'h0000;
    bus.req_s      = 4'h0;
    bus.req_m      = 1'b0;
    bus.req_c_in   = 1'b0;
    bus.resp_ready = 1'b0;
`ifdef ULA_SEQ_SHORT_EN
    bus.req_short  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_f", bus.resp_f, 0);
    chk("rst_c", bus.resp_c_out, 0);
    chk("rst_eq", bus.resp_a_eq_b, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h0F0F, 16'h00FF, 4'b0110, 1'b1, 1'b0, 0, 0);
    do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 0);
    do_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 0);
    do_op(16'h00FF, 16'h0001, 4'b1000, 1'b0, 1'b1, 0, 0);
    do_op(16'h1234, 16'h5534, 4'b0110, 1'b1, 1'b0, 0, 0);
    do_op(16'hA55A, 16'hA55A, 4'b0110, 1'b1, 1'b1, 0, 0);
    do_op(16'h8001, 16'h7F01, 4'b0011, 1'b0, 1'b0, 0, 1);

    // abort during HI pass
    chk("ab_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'hBEEF;
    bus.req_b     = 16'h1111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ab_in_hi", bus.alu_a, 8'hBE);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ab_ready_rst", bus.req_ready, 1);
    chk("ab_valid_rst", bus.resp_valid, 0);
    chk("ab_f_rst", bus.resp_f, 0);
    chk("ab_alu_a", bus.alu_a, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_no_resp", bus.resp_valid, 0);
    end

`ifdef ULA_SEQ_SHORT_EN
    do_op(16'hFFEE, 16'h0012, 4'b1000, 1'b0, 1'b1, 1, 0);
    do_op(16'h3377, 16'h4477, 4'b0110, 1'b1, 1'b0, 1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      do_op(16'($urandom), 16'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 0, (i % 8) == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq_16bits.md
ULA_SEQ_16BITS -- requirements
Module: ula_seq_16bits

Interface
REQ-001 SHALL: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: req_valid  input  1  request present; req_ready  output  1  sequencer can accept.
REQ-004 SHALL: req_a, req_b  input  16 each  operands; req_s  input  4  function select; req_m  input  1  mode (1 = logic); req_c_in  input  1  carry in, ula_8bits polarity.
REQ-005 SHALL: resp_valid  output  1  result held; resp_ready  input  1  consumer takes result.
REQ-006 SHALL: resp_f  output  16  result; resp_c_out  output  1  carry out of high byte; resp_a_eq_b  output  1  16-bit equality flag.
REQ-007 SHALL: alu_a, alu_b  output  8 each; alu_s  output  4; alu_m  output  1; alu_c_in  output  1  drive an external combinational ula_8bits.
REQ-008 SHALL: alu_f  input  8; alu_c_out  input  1; alu_a_eq_b  input  1  results from the same ula_8bits, sampled in the cycle they are driven.

Function
REQ-009 SHALL: FSM states IDLE, LO, HI, DONE, one-hot or binary, encoding free.
REQ-010 SHALL: IDLE: req_ready=1; on req_valid, capture a, b, s, m, c_in into holding registers, go to LO.
REQ-011 SHALL: req_ready=0 in LO, HI, DONE; req_valid is ignored there, with no capture and no error.
REQ-012 SHALL: LO: alu_a=a[7:0], alu_b=b[7:0], alu_s=s, alu_m=m, alu_c_in=captured c_in; at clock edge register resp_f[7:0]=alu_f, carry_lo=alu_c_out, eq_lo=alu_a_eq_b; go to HI.
REQ-013 SHALL: HI: alu_a=a[15:8], alu_b=b[15:8], alu_s=s, alu_m=m, alu_c_in=carry_lo passed unchanged (no inversion); at clock edge register resp_f[15:8]=alu_f, resp_c_out=alu_c_out, resp_a_eq_b=eq_lo AND alu_a_eq_b; go to DONE.
REQ-014 SHALL: In IDLE and DONE, all alu_* outputs = 0.
REQ-015 SHALL: DONE: resp_valid=1; resp_* stable while resp_valid=1 and resp_ready=0; on resp_ready=1, go to IDLE and clear resp_valid.
REQ-016 SHALL: Latency: request accepted at edge N gives resp_valid=1 in the cycle after edge N+2; sustained throughput is one request per 4 cycles.
REQ-017 SHALL: m=1 does not special-case the carry path; carry still chains and reports whatever ula_8bits returns.
REQ-018 SHALL: resp_f/resp_c_out/resp_a_eq_b keep their last value after leaving DONE until overwritten by the next LO/HI.

Reset
REQ-019 SHALL: rst_n=0 at a clock edge forces IDLE; resp_valid=0, resp_f=16'h0000, resp_c_out=0, resp_a_eq_b=0, holding registers and carry_lo/eq_lo=0; req_ready=1 from the first cycle after reset.
REQ-020 SHALL: Reset in LO, HI or DONE aborts the operation; no response is produced for it.

Configuration
REQ-021 SHALL: Macro ULA_SEQ_SHORT_EN defined: add port req_short input 1, captured with the request; when 1, LO goes directly to DONE with resp_f[15:8]=0, resp_c_out=carry_lo, resp_a_eq_b=eq_lo (latency one cycle less).
REQ-022 SHALL: Macro ULA_SEQ_SHORT_EN undefined: port req_short absent; every request takes LO and HI.

Verification
REQ-023 SHALL: Reset then idle: rst_n low 2 cycles -> resp_valid=0, resp_f=0, req_ready=1, alu_a=alu_b=0.
REQ-024 SHALL: Logic XOR: m=1, s=4'b0110, a=16'h0F0F, b=16'h00FF -> LO drives alu_a=8'h0F, alu_b=8'hFF; HI drives 8'h0F/8'h00; resp_f = {HI alu_f, LO alu_f}; resp_valid 3 cycles after accept.
REQ-025 SHALL: Carry chain: m=0, s=4'b1001, a=16'h00FF, b=16'h0001, c_in=either value -> alu_c_in in HI equals alu_c_out sampled in LO; resp_c_out equals HI alu_c_out.
REQ-026 SHALL: Equality: ALU stub returns alu_a_eq_b=1 in LO and 0 in HI -> resp_a_eq_b=0; stub returns 1 in both passes -> resp_a_eq_b=1.
REQ-027 SHALL: Backpressure: resp_ready=0 for 5 cycles in DONE with req_valid=1 and new operands -> resp_* unchanged, req_ready=0; resp_ready=1 -> IDLE next cycle, then new request accepted.
REQ-028 SHALL: Reset mid-op: rst_n=0 during HI -> next cycle IDLE, resp_valid never asserted for that request; with ULA_SEQ_SHORT_EN, req_short=1 -> resp_valid 2 cycles after accept, resp_f[15:8]=0.
